// File: rtl/bcd_mes_loader.sv
//------------------------------------------------------------------------------
// Module   : bcd_mes_loader
// Brief    : Packed-BCD month to binary index converter (reverse double-dabble).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_mes_loader #(
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 12,
  parameter int N       = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   bcd_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] q_out,
  output logic [6:0]   value_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_RANGE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [14:0]    sr_q, sr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [6:0]     val_q, val_d;

  logic [14:0]    w_shift;
  logic [3:0]     w_tens_c;
  logic [3:0]     w_units_c;
  logic [6:0]     w_v;
  logic           w_in_range;

  // Each digit is corrected on its own 4 bits; no borrow crosses digits.
  assign w_shift    = sr_q >> 1;
  assign w_tens_c   = (w_shift[14:11] >= 4'd8) ? (w_shift[14:11] - 4'd3) : w_shift[14:11];
  assign w_units_c  = (w_shift[10:7]  >= 4'd8) ? (w_shift[10:7]  - 4'd3) : w_shift[10:7];
  assign w_v        = sr_q[6:0];
  assign w_in_range = (w_v >= 7'(MIN_VAL)) && (w_v <= 7'(MAX_VAL));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    idx_d   = idx_q;
    val_d   = val_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = {bcd_in, 7'd0};
          cnt_d   = 3'd0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((sr_q[14:11] > 4'd9) || (sr_q[10:7] > 4'd9)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = {w_tens_c, w_units_c, w_shift[6:0]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
          state_d = S_RANGE;
        end
      end
      S_RANGE: begin
        if (w_in_range) begin
          val_d  = w_v;
          idx_d  = N'(w_v - 7'(MIN_VAL));
          done_d = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= 15'd0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      val_q   <= 7'(MIN_VAL);
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign q_out     = idx_q;
  assign value_out = val_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_mes_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_bcd_mes_loader
// Brief    : Self-checking bench for bcd_mes_loader (vector table + random model).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_mes_loader;

  localparam int MIN_VAL = 1;
  localparam int MAX_VAL = 12;
  localparam int N       = 4;

  // Result kinds: 0 = done, 1 = digit error after CHECK, 2 = range error.
  typedef struct {
    logic [7:0] bcd;
    int         kind;
    int         q;
    int         v;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   bcd_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] q_out;
  logic [6:0]   value_out;

  int checks   = 0;
  int failures = 0;
  int exp_q    = 0;
  int exp_v    = MIN_VAL;

  always #5 clk = ~clk;

  bcd_mes_loader #(.MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .q_out     (q_out),
    .value_out (value_out)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: decimal value from digits, then legality and range rules.
  task automatic model(input logic [7:0] b, output int kind, output int q, output int v);
    int tens, units, val;
    tens  = int'(b[7:4]);
    units = int'(b[3:0]);
    val   = tens * 10 + units;
    q = exp_q;
    v = exp_v;
    if (tens > 9 || units > 9)              kind = 1;
    else if (val < MIN_VAL || val > MAX_VAL) kind = 2;
    else begin
      kind = 0;
      v    = val;
      q    = (val - MIN_VAL) % (1 << N);
    end
  endtask

  // One conversion; extra_k >= 0 raises start for one cycle during busy.
  task automatic run_conv(input logic [7:0] b, input int kind, input int eq, input int ev,
                          input int extra_k, input string nm);
    int first_k  = -1;
    int busy_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both     = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      start  = (k == extra_k);
      bcd_in = 8'($urandom);
      busy_cnt += int'(busy);
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (done && err) both++;
      if ((done || err) && first_k < 0) first_k = k;
    end
    start = 1'b0;
    chk({nm, " latency"},   first_k,  (kind == 1) ? 1 : 9);
    chk({nm, " busy_cyc"},  busy_cnt, (kind == 1) ? 1 : 9);
    chk({nm, " done_cnt"},  done_cnt, (kind == 0) ? 1 : 0);
    chk({nm, " err_cnt"},   err_cnt,  (kind == 0) ? 0 : 1);
    chk({nm, " overlap"},   both,     0);
    if (kind == 0) begin
      exp_q = eq;
      exp_v = ev;
    end
    chk({nm, " q_out"},     int'(q_out),     exp_q);
    chk({nm, " value_out"}, int'(value_out), exp_v);
  endtask

  vec_t tbl[$];

  initial begin
    int kind, q, v;
    int dcnt, first_d, last_d, gap_bad, stray;
    logic [7:0] b;

    tbl.push_back('{8'h12, 0, 11, 12});
    tbl.push_back('{8'h01, 0, 0,  1});
    tbl.push_back('{8'h09, 0, 8,  9});
    tbl.push_back('{8'h10, 0, 9,  10});
    tbl.push_back('{8'h1A, 1, 0,  0});
    tbl.push_back('{8'hB2, 1, 0,  0});
    tbl.push_back('{8'h00, 2, 0,  0});
    tbl.push_back('{8'h13, 2, 0,  0});
    tbl.push_back('{8'h99, 2, 0,  0});

    // Reset, with start held to show reset wins.
    reset  = 1'b1;
    start  = 1'b1;
    bcd_in = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy",  int'(busy),      0);
    chk("rst done",  int'(done),      0);
    chk("rst err",   int'(err),       0);
    chk("rst q_out", int'(q_out),     0);
    chk("rst value", int'(value_out), MIN_VAL);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      run_conv(tbl[i].bcd, tbl[i].kind, tbl[i].q, tbl[i].v, -1, $sformatf("vec%0d", i));
    end

    // start pulsed mid-conversion is ignored.
    run_conv(8'h07, 0, 6, 7, 3, "ignore_start");

    // start held high: back-to-back conversions every 10 cycles.
    dcnt = 0; first_d = -1; last_d = -1; gap_bad = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 8'h05;
    for (int c = 0; c <= 50; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcnt++;
        if (first_d < 0) first_d = c;
        else if (c - last_d != 10) gap_bad++;
        last_d = c;
      end
      if (c == 39) start = 1'b0;
    end
    chk("held done_cnt",  dcnt,    4);
    chk("held first",     first_d, 9);
    chk("held gap_bad",   gap_bad, 0);
    chk("held q_out",     int'(q_out),     4);
    chk("held value_out", int'(value_out), 5);
    exp_q = 4;
    exp_v = 5;

    // Reset during conversion aborts it.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 8'h07;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy",  int'(busy),      0);
    chk("abort done",  int'(done),      0);
    chk("abort err",   int'(err),       0);
    chk("abort q_out", int'(q_out),     0);
    chk("abort value", int'(value_out), MIN_VAL);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done || err || busy) stray++;
    end
    chk("abort quiet", stray, 0);
    exp_q = 0;
    exp_v = MIN_VAL;

    // Randomized conversions against the reference model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else if ($urandom_range(0, 1) == 1)
        b = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      else
        b = 8'($urandom);
      model(b, kind, q, v);
      run_conv(b, kind, q, v, (kind == 1) ? -1 : int'($urandom_range(0, 7)),
               $sformatf("rnd%0d_%02h", i, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
